// File: rtl/req_arb_pkg.sv
// Shared defaults, index type and offer-state encoding for the request arbiter.
package req_arb_pkg;

  localparam int unsigned N_REQ_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;

  typedef logic [$clog2(N_REQ_DEF)-1:0] idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/req_onehot_arbiter_onehot_pick.sv
// Combinational first-set picker starting just above a base index, wrapping
// modulo N. With base = N-1 the search starts at bit 0 (fixed priority).
module onehot_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         pending,
  input  logic [$clog2(N)-1:0] base,
  output logic [N-1:0]         pick,
  output logic [$clog2(N)-1:0] pick_idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] k;

  // Walk the rotated request vector and keep the first pending bit found.
  // N is a power of two, so the IW-bit add wraps modulo N for free.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    k        = '0;
    for (int unsigned j = 0; j < N; j++) begin
      k = base + IW'(1) + IW'(j);
      if (!any && pending[k]) begin
        any      = 1'b1;
        pick_idx = k;
        pick[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_onehot_arbiter.sv
// Sticky-request arbiter feeding the 8-to-3 encoder: captures request pulses
// into pending bits and issues them one at a time as a registered one-hot
// word under a valid/ready handshake, counting merged (dropped) requests.
// Optional macro REQ_ARB_ROUND_ROBIN_EN: round-robin selection from ptr+1;
// without it, fixed lowest-index priority and no pointer register.
module req_onehot_arbiter
  import req_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] out_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_REQ-1:0] pending_o,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             clear_drop
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned SW = CNT_W + IW + 1;

  state_t           state, state_next;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] pick;
  logic [N_REQ-1:0] load_mask;
  logic [N_REQ-1:0] drop_bits;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    base;
  logic             any;
  logic             slot_free;
  logic             load;
  logic [SW-1:0]    drop_sum;
  logic [CNT_W-1:0] drop_next;

`ifdef REQ_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;

  // Remember the last granted index so the next search starts just above it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '1;
    end else if (load) begin
      ptr <= pick_idx;
    end
  end

  assign base = ptr;
`else
  assign base = '1;
`endif

  onehot_pick #(.N(N_REQ)) u_pick (
    .pending  (pending),
    .base     (base),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  assign out_valid = (state == ST_OFFER);
  assign pending_o = pending;

  // Slot availability, load decision and next offer state.
  always_comb begin
    slot_free  = (state == ST_EMPTY) || out_ready;
    load       = slot_free && any;
    load_mask  = '0;
    if (load) begin
      load_mask[pick_idx] = 1'b1;
    end
    state_next = state;
    if (slot_free) begin
      state_next = any ? ST_OFFER : ST_EMPTY;
    end
  end

  // Count requests merged into a bit that stays pending, saturating at all-ones.
  always_comb begin
    drop_bits = req_i & pending & ~load_mask;
    drop_sum  = SW'(drop_cnt);
    for (int unsigned j = 0; j < N_REQ; j++) begin
      drop_sum = drop_sum + SW'(drop_bits[j]);
    end
    drop_next = (drop_sum > SW'({CNT_W{1'b1}})) ? '1 : CNT_W'(drop_sum);
  end

  // Pending capture, output register, offer state and drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      pending    <= '0;
      out_onehot <= '0;
      drop_cnt   <= '0;
    end else begin
      state   <= state_next;
      pending <= (pending & ~load_mask) | req_i;
      if (slot_free) begin
        out_onehot <= load ? pick : '0;
      end
      drop_cnt <= clear_drop ? '0 : drop_next;
    end
  end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Self-checking bench for req_onehot_arbiter with a behavioural model of
// pending bits, the offered grant and the drop counter.
module tb_req_onehot_arbiter;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req_i = '0;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] pending_o;
  logic [7:0] drop_cnt;
  logic       clear_drop = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Model state
  bit m_pend[N];
  bit m_valid;
  int m_idx;
  int m_drop;
  int m_ptr;

  req_onehot_arbiter #(.N_REQ(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .pending_o  (pending_o),
    .drop_cnt   (drop_cnt),
    .clear_drop (clear_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_pend();
    logic [7:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [7:0] exp_oh();
    logic [7:0] v;
    v = '0;
    if (m_valid) v[m_idx] = 1'b1;
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model by the arbitration rules,
  // then clock and settle past the edge.
  task automatic cycle(input logic [7:0] r, input logic rdy, input logic clr, input logic rs);
    bit free;
    int pick;
    int drops;
    req_i = r; out_ready = rdy; clear_drop = clr; rst = rs;
    if (rs) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_valid = 0; m_idx = 0; m_drop = 0; m_ptr = N - 1;
    end else begin
      free  = !m_valid || rdy;
      pick  = -1;
      drops = 0;
      if (free) begin
`ifdef REQ_ARB_ROUND_ROBIN_EN
        for (int j = 1; j <= N; j++)
          if (pick < 0 && m_pend[(m_ptr + j) % N]) pick = (m_ptr + j) % N;
`else
        for (int i = 0; i < N; i++)
          if (pick < 0 && m_pend[i]) pick = i;
`endif
      end
      for (int i = 0; i < N; i++)
        if (r[i] && m_pend[i] && i != pick) drops++;
      if (clr) m_drop = 0;
      else m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
      if (free) begin
        m_valid = (pick >= 0);
        if (pick >= 0) begin
          m_idx = pick;
          m_pend[pick] = 0;
          m_ptr = pick;
        end
      end
      for (int i = 0; i < N; i++)
        if (r[i]) m_pend[i] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    chk_cnt++;
    if ({out_valid, out_onehot, pending_o, drop_cnt} !== 25'd0)
      $display("FAIL reset: valid=%b oh=%h pend=%h drop=%h, want all 0", out_valid, out_onehot, pending_o, drop_cnt);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [2:0] y;
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    cycle(8'h10, 1'b1, 1'b0, 1'b0);
    chk_cnt++;
    if (out_valid !== 1'b0 || pending_o !== 8'h10)
      $display("FAIL single_lat1: valid=%b pend=%h, want 0/10", out_valid, pending_o);
    else pass_cnt++;
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    y = {out_onehot[4] | out_onehot[5] | out_onehot[6] | out_onehot[7],
         out_onehot[2] | out_onehot[3] | out_onehot[6] | out_onehot[7],
         out_onehot[1] | out_onehot[3] | out_onehot[5] | out_onehot[7]};
    chk_cnt++;
    if (out_valid !== 1'b1 || out_onehot !== 8'h10 || y !== 3'd4)
      $display("FAIL single_grant: valid=%b oh=%h y=%0d, want 1/10/4", out_valid, out_onehot, y);
    else pass_cnt++;
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    chk_cnt++;
    if (out_valid !== 1'b0 || out_onehot !== 8'h00)
      $display("FAIL single_once: valid=%b oh=%h, want 0/00", out_valid, out_onehot);
    else pass_cnt++;
  endtask

  task automatic test_fixed_priority();
    logic [7:0] want [4];
    want = '{8'h01, 8'h04, 8'h20, 8'h80};
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    cycle(8'hA5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(8'h00, 1'b1, 1'b0, 1'b0);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_onehot !== want[k])
        $display("FAIL prio_grant%0d: valid=%b oh=%h, want 1/%h", k, out_valid, out_onehot, want[k]);
      else pass_cnt++;
    end
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    chk_cnt++;
    if (out_valid !== 1'b0 || out_onehot !== 8'h00 || drop_cnt !== 8'h00)
      $display("FAIL prio_end: valid=%b oh=%h drop=%h, want 0/00/00", out_valid, out_onehot, drop_cnt);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    cycle(8'h03, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(8'h00, 1'b0, 1'b0, 1'b0);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_onehot !== 8'h01 || pending_o !== 8'h02)
        $display("FAIL bp_hold%0d: valid=%b oh=%h pend=%h, want 1/01/02", k, out_valid, out_onehot, pending_o);
      else pass_cnt++;
    end
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_onehot !== 8'h02 || pending_o !== 8'h00)
      $display("FAIL bp_second: valid=%b oh=%h pend=%h, want 1/02/00", out_valid, out_onehot, pending_o);
    else pass_cnt++;
    cycle(8'h00, 1'b1, 1'b0, 1'b0);
    chk_cnt++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_empty: valid=%b, want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_drops();
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) cycle(8'h01, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (out_onehot !== 8'h01 || pending_o !== 8'h01 || drop_cnt !== 8'd2)
      $display("FAIL drop_count: oh=%h pend=%h drop=%0d, want 01/01/2", out_onehot, pending_o, drop_cnt);
    else pass_cnt++;
    cycle(8'h01, 1'b0, 1'b1, 1'b0);
    chk_cnt++;
    if (drop_cnt !== 8'd0)
      $display("FAIL drop_clear: drop=%0d, want 0", drop_cnt);
    else pass_cnt++;
    for (int k = 0; k < 45; k++) cycle(8'hFF, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (drop_cnt !== 8'hFF)
      $display("FAIL drop_sat: drop=%h, want ff", drop_cnt);
    else pass_cnt++;
    cycle(8'hFF, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (drop_cnt !== 8'hFF)
      $display("FAIL drop_sat_hold: drop=%h, want ff", drop_cnt);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] want [4];
`ifdef REQ_ARB_ROUND_ROBIN_EN
    want = '{8'h01, 8'h80, 8'h01, 8'h80};
`else
    want = '{8'h01, 8'h01, 8'h01, 8'h01};
`endif
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    cycle(8'h81, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(8'h81, 1'b1, 1'b0, 1'b0);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_onehot !== want[k])
        $display("FAIL rr_grant%0d: valid=%b oh=%h, want 1/%h", k, out_valid, out_onehot, want[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    cycle(8'hFF, 1'b0, 1'b0, 1'b0);
    cycle(8'h01, 1'b0, 1'b0, 1'b0);
    chk_cnt++;
    if (out_valid !== 1'b1 || pending_o !== 8'hFF)
      $display("FAIL rstmid_setup: valid=%b pend=%h, want 1/ff", out_valid, pending_o);
    else pass_cnt++;
    cycle(8'h00, 1'b1, 1'b0, 1'b1);
    chk_cnt++;
    if ({out_valid, out_onehot, pending_o, drop_cnt} !== 25'd0)
      $display("FAIL rstmid_clear: valid=%b oh=%h pend=%h drop=%h, want all 0", out_valid, out_onehot, pending_o, drop_cnt);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      cycle(8'h00, 1'b1, 1'b0, 1'b0);
      chk_cnt++;
      if (out_valid !== 1'b0 || out_onehot !== 8'h00)
        $display("FAIL rstmid_nogrant%0d: valid=%b oh=%h, want 0/00", k, out_valid, out_onehot);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    cycle(8'h00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 400; k++) begin
      r = 8'($urandom) & 8'($urandom);
      cycle(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 127) == 0));
      chk_cnt++;
      if (out_valid !== m_valid || out_onehot !== exp_oh() || pending_o !== exp_pend()
          || drop_cnt !== 8'(m_drop))
        $display("FAIL random%0d: valid=%b oh=%h pend=%h drop=%0d, want %b/%h/%h/%0d",
                 k, out_valid, out_onehot, pending_o, drop_cnt, m_valid, exp_oh(), exp_pend(), m_drop);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_priority();
    test_backpressure();
    test_drops();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/req_onehot_arbiter.md
Name: req_onehot_arbiter

Overview:
- Upstream stage of the 8-to-3 encoder.
- Captures single-cycle request pulses on N_REQ lines into sticky pending bits.
- Issues them one at a time as a registered one-hot word with a valid/ready handshake.
- out_onehot drives the encoder's D input directly. It is guaranteed one-hot or all-zero, so the encoder's OR-based mapping is always exact.

Parameters:
- N_REQ, 8: number of request lines; power of 2, at least 2; 8 for the encoder pairing.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_i  in  N_REQ  request pulses; any number may be high in one cycle.
- out_onehot  out  N_REQ  granted request, one-hot; all-zero when out_valid=0.
- out_valid  out  1  out_onehot holds a grant.
- out_ready  in  1  consumer accepts; handshake = out_valid & out_ready.
- pending_o  out  N_REQ  pending bits not yet loaded into the output register.
- drop_cnt  out  CNT_W  count of requests merged into an already-pending bit; saturates at all-ones.
- clear_drop  in  1  synchronous clear of drop_cnt.

Behaviour:
- Reset values: out_onehot=0, out_valid=0, pending=0, drop_cnt=0, RR pointer=N_REQ-1. Reset mid-handshake discards all pending and offered requests.
- Pending update per edge: pending_next = (pending & ~load_mask) | req_i.
  - A request on the bit being loaded in the same cycle wins and stays pending.
- Output slot is free when out_valid=0 or a handshake occurs this cycle.
- When the slot is free and pending is nonzero:
  - pick one bit via the selection rule;
  - load it into out_onehot and set out_valid=1;
  - load_mask = picked bit.
- When the slot is free and pending=0, out_valid goes to 0 and out_onehot goes to 0.
- While out_valid=1 and out_ready=0, out_onehot is held stable and pending bits keep accumulating.
- Latency: req_i high at edge t makes pending visible after t. out_valid rises after edge t+1 if the slot is free (2 cycles). Back-to-back grants sustain 1 per cycle with out_ready held high.
- A request on the currently offered bit (out_onehot) sets the pending bit again, giving a second grant later. This is not a drop.
- Drop: req_i[i]=1 while pending[i]=1 and bit i is not loaded this cycle.
  - drop_cnt += popcount of such bits, saturating.
  - clear_drop has priority over increment in the same cycle.
- Default selection: fixed priority, lowest index wins.
- States, implicit: EMPTY (out_valid=0), OFFER (out_valid=1).
  - EMPTY to OFFER: pending nonzero.
  - OFFER to OFFER: handshake with pending nonzero, or no handshake.
  - OFFER to EMPTY: handshake with pending=0.

Optional Feature:
- Macro: REQ_ARB_ROUND_ROBIN_EN.
- Defined:
  - Selection searches from index ptr+1 upward, wrapping modulo N_REQ, and picks the first pending bit.
  - ptr updates to the picked index on each load.
  - Reset ptr=N_REQ-1, so the first pick matches fixed priority.
- Undefined: fixed lowest-index priority, and no pointer register exists.

Decomposition:
- Package req_arb_pkg holds:
  - N_REQ_DEF=8, CNT_W_DEF=8;
  - idx_t (clog2 of N_REQ bits);
  - state enum {ST_EMPTY, ST_OFFER}.
- Sub-module onehot_pick: combinational.
  - Inputs: pending, base index.
  - Outputs: one-hot pick, pick index, any flag.
  - Rotate, find first set, rotate back. With base fixed at N_REQ-1 it gives fixed priority.

Test Plan:
- Single request: req_i=8'h10 for 1 cycle, out_ready=1 -> out_valid=1 with out_onehot=8'h10 two cycles later for exactly 1 cycle; encoder y=3'd4.
- Simultaneous, fixed priority: req_i=8'hA5 once, out_ready=1 -> grants 01,04,20,80 on consecutive cycles, then out_valid=0; drop_cnt=0.
- Backpressure: req_i=8'h03, out_ready=0 for 5 cycles -> out_onehot stays 8'h01 and pending_o=8'h02. Raise out_ready -> 01 accepted, then 02.
- Drops: out_ready=0, req_i=8'h01 on 4 consecutive cycles -> out_onehot=01, then one pending, then drop_cnt=2. clear_drop together with a further drop leaves drop_cnt=0. Forcing saturation holds drop_cnt at 8'hFF.
- Round robin (REQ_ARB_ROUND_ROBIN_EN): hold req_i=8'h81 every cycle, out_ready=1 -> grants alternate 01,80,01,80. Without the macro the grants are 01 on every cycle.
- Reset mid-operation: pending=8'hFF, out_valid=1, assert rst 1 cycle -> next cycle all outputs 0, pending_o=0, and no grant follows.
